// File: rtl/bgd_pkg.sv
// Shared BGD datapath types and constants.
package bgd_pkg;

  localparam int unsigned BGD_DATA_W  = 14;
  localparam int unsigned BGD_MUL_LAT = 3;
  localparam int unsigned BGD_N_REQ   = 4;
  localparam int unsigned BGD_ID_W    = $clog2(BGD_N_REQ);

  typedef logic signed [BGD_DATA_W-1:0] bgd_data_t;

  // One stage of the ID tag pipe that travels alongside the multiplier.
  typedef struct packed {
    logic                v;
    logic [BGD_ID_W-1:0] id;
  } bgd_tag_t;

endpackage

// File: rtl/bgd_mul_share_arb_if.sv
// Request, response and multiplier-port bundle for the shared multiplier arbiter.
interface bgd_mul_share_arb_if
  import bgd_pkg::*;
#(
  parameter int unsigned N_REQ  = BGD_N_REQ,
  parameter int unsigned DATA_W = BGD_DATA_W,
  parameter int unsigned ID_W   = $clog2(N_REQ)
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_a;
  logic [N_REQ*DATA_W-1:0] req_b;
  logic [N_REQ-1:0]        req_ready;
  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [DATA_W-1:0]       rsp_data;
  logic                    rsp_ready;
  logic                    mul_ce;
  logic [DATA_W-1:0]       mul_din0;
  logic [DATA_W-1:0]       mul_din1;
  logic [DATA_W-1:0]       mul_dout;
  logic                    busy;

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_dout,
    output req_ready, rsp_valid, rsp_id, rsp_data, mul_ce, mul_din0, mul_din1, busy
  );

  // Requesters / response consumer / multiplier side.
  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_dout,
    input  req_ready, rsp_valid, rsp_id, rsp_data, mul_ce, mul_din0, mul_din1, busy
  );

endinterface

// File: rtl/bgd_rr_arb.sv
// Round-robin picker: first requester at or after ptr, wrapping to index 0.
module bgd_rr_arb #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id
);

  logic           found_hi;
  logic           found_lo;
  logic [IDW-1:0] id_hi;
  logic [IDW-1:0] id_lo;

  // Rotating search split into an upper (>= ptr) and a wrapped pass; the upper hit has priority.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    id_hi    = '0;
    id_lo    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found_hi && req[i] && (32'(ptr) <= i)) begin
        found_hi = 1'b1;
        id_hi    = IDW'(i);
      end
      if (!found_lo && req[i]) begin
        found_lo = 1'b1;
        id_lo    = IDW'(i);
      end
    end
    gnt_id = found_hi ? id_hi : id_lo;
    for (int unsigned i = 0; i < N; i++) begin
      gnt[i] = en && (found_hi || found_lo) && (gnt_id == IDW'(i));
    end
  end

endmodule

// File: rtl/bgd_mul_share_arb.sv
// Shares one ce-gated pipelined multiplier between N_REQ requesters with a
// parallel ID tag pipe; response backpressure freezes multiplier and tags together.
module bgd_mul_share_arb
  import bgd_pkg::*;
#(
  parameter int unsigned N_REQ   = BGD_N_REQ,
  parameter int unsigned DATA_W  = BGD_DATA_W,
  parameter int unsigned MUL_LAT = BGD_MUL_LAT,
  parameter int unsigned ID_W    = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  bgd_mul_share_arb_if.slave  bus
);

  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  ptr;
  logic             issue;
  logic             arb_en;
  bgd_tag_t         tag [MUL_LAT];

  // Stall whenever the head result is waiting on the consumer.
  assign bus.mul_ce = !(tag[MUL_LAT-1].v && !bus.rsp_ready);
  // No grants while reset is held, so nothing is handed over only to be discarded.
  assign arb_en     = bus.mul_ce && !reset;

  bgd_rr_arb #(
    .N   (N_REQ),
    .IDW (ID_W)
  ) u_arb (
    .req    (bus.req_valid),
    .ptr    (ptr),
    .en     (arb_en),
    .gnt    (gnt),
    .gnt_id (grant_id)
  );

  assign bus.req_ready = gnt;
  assign issue         = |(bus.req_valid & gnt);

  // Operand mux driven by the one-hot grant; zero when nothing issues.
  always_comb begin
    bus.mul_din0 = '0;
    bus.mul_din1 = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        bus.mul_din0 = bus.req_a[i*DATA_W +: DATA_W];
        bus.mul_din1 = bus.req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  // Round-robin pointer moves past the requester just served.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (issue) begin
      ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Tag pipe advances in lockstep with the multiplier's ce.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < MUL_LAT; i++) begin
        tag[i] <= '0;
      end
    end else if (bus.mul_ce) begin
      tag[0] <= {issue, BGD_ID_W'(grant_id)};
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        tag[i] <= tag[i-1];
      end
    end
  end

  assign bus.rsp_valid = tag[MUL_LAT-1].v;
  assign bus.rsp_id    = ID_W'(tag[MUL_LAT-1].id);
  assign bus.rsp_data  = bus.mul_dout;

  // Any tag still in flight keeps busy high.
  always_comb begin
    bus.busy = 1'b0;
    for (int unsigned i = 0; i < MUL_LAT; i++) begin
      bus.busy = bus.busy | tag[i].v;
    end
  end

endmodule

// File: tb/tb_bgd_mul_share_arb.sv
// Self-checking bench for bgd_mul_share_arb with a ce-gated reference multiplier
// and a response scoreboard.
module tb_bgd_mul_share_arb;
  import bgd_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned DW  = 14;
  localparam int unsigned LAT = 3;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
  } sb_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int checks    = 0;
  int failures  = 0;
  int rsp_cnt   = 0;

  sb_t             sb [$];
  int              gnt_log [$];
  logic [DW-1:0]   last_rsp_data;
  logic [1:0]      last_rsp_id;

  always #5 clk = ~clk;

  bgd_mul_share_arb_if #(.N_REQ(N), .DATA_W(DW), .ID_W(2)) bus ();

  bgd_mul_share_arb #(
    .N_REQ   (N),
    .DATA_W  (DW),
    .MUL_LAT (LAT),
    .ID_W    (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference multiplier: LAT register stages, all gated by mul_ce, no reset.
  logic signed [2*DW-1:0] mfull;
  logic [DW-1:0]          mp [LAT];
  assign mfull        = $signed(bus.mul_din0) * $signed(bus.mul_din1);
  assign bus.mul_dout = mp[LAT-1];
  always_ff @(posedge clk) begin
    if (bus.mul_ce) begin
      mp[0] <= mfull[DW-1:0];
      for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] prod14(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    logic signed [2*DW-1:0] f;
    f = a * b;
    return f[DW-1:0];
  endfunction

  // Monitor: pop/compare accepted responses, then push newly issued operations.
  always @(negedge clk) begin
    if (bus.rsp_valid && bus.rsp_ready) begin
      sb_t e;
      rsp_cnt++;
      last_rsp_data = bus.rsp_data;
      last_rsp_id   = bus.rsp_id;
      chk_eq("sb_has_entry", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk_eq("rsp_id", bus.rsp_id, e.id);
        chk_eq("rsp_data", bus.rsp_data, e.data);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        sb.push_back({2'(i), prod14(bus.req_a[i*DW +: DW], bus.req_b[i*DW +: DW])});
        gnt_log.push_back(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    bus.req_a[i*DW +: DW] = DW'(a);
    bus.req_b[i*DW +: DW] = DW'(b);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int base;
    int k;
    logic xfer;
    logic [DW-1:0] exp0;

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    reset         = 1'b1;

    // Reset state, including no grant while reset is held.
    repeat (2) tick();
    chk_eq("rst_rsp_valid", bus.rsp_valid, 0);
    chk_eq("rst_busy", bus.busy, 0);
    chk_eq("rst_mul_ce", bus.mul_ce, 1);
    chk_eq("rst_din0", bus.mul_din0, 0);
    chk_eq("rst_din1", bus.mul_din1, 0);
    bus.req_valid = '1;
    #1;
    chk_eq("rst_req_ready", bus.req_ready, 0);
    bus.req_valid = '0;
    tick();
    reset = 1'b0;

    // Single requester 0: 3 * -5, latency MUL_LAT.
    set_op(0, 3, -5);
    bus.req_valid = 4'b0001;
    #1;
    chk_eq("single_ready", bus.req_ready, 4'b0001);
    chk_eq("single_din0", bus.mul_din0, 14'd3);
    tick();
    bus.req_valid = '0;
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
      @(posedge clk);
      lat++;
    end
    chk_eq("single_latency", lat, 3);
    chk_eq("single_id", bus.rsp_id, 0);
    chk_eq("single_data", bus.rsp_data, 14'h3FF1);
    repeat (3) tick();

    // All four valid for 8 cycles from ptr=0: strict rotation, 1 result/cycle.
    do_reset();
    gnt_log.delete();
    base = rsp_cnt;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) set_op(i, int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)));
      bus.req_valid = '1;
      tick();
    end
    bus.req_valid = '0;
    repeat (3) tick();
    chk_eq("rr_rsp_count", rsp_cnt - base, 8);
    chk_eq("rr_gnt_count", gnt_log.size(), 8);
    for (int j = 0; j < 8 && j < gnt_log.size(); j++) chk_eq("rr_gnt_order", gnt_log[j], j % 4);
    repeat (2) tick();

    // Wrap: 127 * 200 = 25400 -> low 14 bits 9016.
    set_op(0, 127, 200);
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = '0;
    repeat (4) tick();
    chk_eq("wrap_data", last_rsp_data, 14'h2338);

    // Requester 2 streams 5 ops; consumer stalls 4 cycles once the head is valid.
    base = rsp_cnt;
    exp0 = prod14(14'sd10, -14'sd3);
    k = 0;
    for (int c = 0; c < 20; c++) begin
      bus.rsp_ready = !(c >= 3 && c < 7);
      if (k < 5) begin
        set_op(2, 10 + k, -(k + 3));
        bus.req_valid = 4'b0100;
      end else begin
        bus.req_valid = '0;
      end
      #1;
      if (c >= 3 && c < 7) begin
        chk_eq("stall_mul_ce", bus.mul_ce, 0);
        chk_eq("stall_req_ready", bus.req_ready, 0);
        chk_eq("stall_rsp_valid", bus.rsp_valid, 1);
        chk_eq("stall_rsp_id", bus.rsp_id, 2);
        chk_eq("stall_rsp_data", bus.rsp_data, exp0);
      end
      xfer = bus.req_valid[2] && bus.req_ready[2];
      tick();
      if (xfer) k++;
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    chk_eq("stream_issued", k, 5);
    chk_eq("stream_rsp_count", rsp_cnt - base, 5);

    // Requesters 1 and 3 with ptr=2: 3 first, then 1.
    do_reset();
    set_op(1, 4, 4);
    bus.req_valid = 4'b0010;
    tick();
    chk_eq("ptr_after_1", dut.ptr, 2);
    set_op(3, 6, 7);
    bus.req_valid = 4'b1010;
    #1;
    chk_eq("pair_first", bus.req_ready, 4'b1000);
    tick();
    chk_eq("pair_ptr0", dut.ptr, 0);
    chk_eq("pair_second", bus.req_ready, 4'b0010);
    tick();
    chk_eq("pair_ptr2", dut.ptr, 2);
    bus.req_valid = '0;
    repeat (5) tick();

    // Reset with three ops in flight: all discarded; the next op returns correctly.
    do_reset();
    for (int j = 0; j < 3; j++) begin
      set_op(0, j + 1, 5);
      bus.req_valid = 4'b0001;
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    reset = 1'b1;
    chk_eq("inflight_busy", bus.busy, 1);
    tick();
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    sb.delete();
    chk_eq("midrst_busy", bus.busy, 0);
    chk_eq("midrst_rsp_valid", bus.rsp_valid, 0);
    base = rsp_cnt;
    set_op(1, -7, 9);
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = '0;
    repeat (5) tick();
    chk_eq("post_rst_count", rsp_cnt - base, 1);
    chk_eq("post_rst_data", last_rsp_data, prod14(-14'sd7, 14'sd9));
    chk_eq("post_rst_id", last_rsp_id, 1);

    chk_eq("sb_drained", sb.size(), 0);
    chk_eq("final_busy", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
